mmu_skew_feeder: RTL and testbench

- Transmit side of the MMU column path: takes 2-lane row vectors from the unified-buffer side and drives them into the 2x2 systolic MMU with diagonal skew.
- Lane 1 lags lane 0 by exactly one cycle, which is the skew the output aligner removes.
- Small input FIFO, per-tile framing via a last flag, and a one-cycle tile_done pulse aligned with the final lane-1 element.

---
 rtl/mmu_skew_feeder.sv | 131 +++++++++++++
 tb/tb_mmu_skew_feeder.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mmu_skew_feeder.sv
// Transmit side of the MMU column path: buffers 2-lane row vectors and drives
// them into the 2x2 systolic array with lane 1 skewed one cycle behind lane 0.
module mmu_skew_feeder #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 4,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_vec0,
    input  logic [DATA_W-1:0] in_vec1,
    input  logic              in_last,
    output logic [DATA_W-1:0] mmu_row0_out,
    output logic [DATA_W-1:0] mmu_row1_out,
    output logic              mmu_valid0,
    output logic              mmu_valid1,
    output logic              tile_done,
    output logic              busy,
    output logic [CNT_W-1:0]  vec_count,
    output logic              underrun
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);
    localparam logic [CNT_W-1:0] ONE_CNT = {{(CNT_W-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {IDLE, STREAM, DRAIN} state_t;

    state_t            state;
    logic [DATA_W-1:0] mem_vec0 [DEPTH];
    logic [DATA_W-1:0] mem_vec1 [DEPTH];
    logic              mem_last [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [PTR_W:0]    count;
    logic [DATA_W-1:0] lane1_stage;
    logic              lane1_stage_valid;
    logic              push;
    logic              pop;
    logic              full;
    logic              empty;
    logic [DATA_W-1:0] head_vec0;
    logic [DATA_W-1:0] head_vec1;
    logic              head_last;

    // in_ready is held low during reset so nothing is accepted into a FIFO being cleared
    assign full      = (count == FULL_CNT);
    assign empty     = (count == '0);
    assign in_ready  = reset_n && !full;
    assign push      = in_valid && in_ready;
    assign pop       = (state != DRAIN) && !empty;
    assign busy      = (state != IDLE);
    assign head_vec0 = mem_vec0[rd_ptr];
    assign head_vec1 = mem_vec1[rd_ptr];
    assign head_last = mem_last[rd_ptr];

    always_ff @(posedge clk) begin
        if (push) begin
            mem_vec0[wr_ptr] <= in_vec0;
            mem_vec1[wr_ptr] <= in_vec1;
            mem_last[wr_ptr] <= in_last;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state             <= IDLE;
            mmu_row0_out      <= '0;
            mmu_valid0        <= 1'b0;
            lane1_stage       <= '0;
            lane1_stage_valid <= 1'b0;
            mmu_row1_out      <= '0;
            mmu_valid1        <= 1'b0;
            tile_done         <= 1'b0;
            vec_count         <= '0;
            underrun          <= 1'b0;
        end else begin
            mmu_row0_out      <= pop ? head_vec0 : '0;
            mmu_valid0        <= pop;
            lane1_stage       <= pop ? head_vec1 : '0;
            lane1_stage_valid <= pop;
            mmu_row1_out      <= lane1_stage;
            mmu_valid1        <= lane1_stage_valid;
            // The DRAIN->IDLE edge is exactly when the tile's last lane-1 element reaches the output
            tile_done         <= (state == DRAIN);

            case (state)
                IDLE: begin
                    if (pop) begin
                        vec_count <= ONE_CNT;
                        underrun  <= 1'b0;
                        state     <= head_last ? DRAIN : STREAM;
                    end
                end
                STREAM: begin
                    if (pop) begin
                        if (vec_count != '1) vec_count <= vec_count + 1'b1;
                        if (head_last) state <= DRAIN;
                    end else begin
                        underrun <= 1'b1;
                    end
                end
                DRAIN: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mmu_skew_feeder.sv
// Self-checking bench for mmu_skew_feeder: directed and random traffic compared
// against a queue-based reference of the skewed feed.
module tb_mmu_skew_feeder;

    localparam int DATA_W = 8;
    localparam int DEPTH  = 4;
    localparam int CNT_W  = 8;

    typedef struct packed {
        logic [7:0] v0;
        logic [7:0] v1;
        logic       last;
    } vec_t;

    logic              clk = 1'b0;
    logic              reset_n = 1'b1;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [DATA_W-1:0] in_vec0 = '0;
    logic [DATA_W-1:0] in_vec1 = '0;
    logic              in_last = 1'b0;
    logic [DATA_W-1:0] mmu_row0_out;
    logic [DATA_W-1:0] mmu_row1_out;
    logic              mmu_valid0;
    logic              mmu_valid1;
    logic              tile_done;
    logic              busy;
    logic [CNT_W-1:0]  vec_count;
    logic              underrun;

    int checks = 0;
    int errors = 0;

    // Reference model: pending vectors, tile progress and the one-cycle lane-1 delay
    vec_t       m_q[$];
    bit         m_drain;
    bit         m_in_tile;
    int         m_cnt;
    bit         m_und;
    logic [7:0] m_stage_d;
    bit         m_stage_v;
    logic [7:0] exp_row0;
    bit         exp_v0;
    logic [7:0] exp_row1;
    bit         exp_v1;
    bit         exp_done;

    mmu_skew_feeder #(.DATA_W(DATA_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_vec0      (in_vec0),
        .in_vec1      (in_vec1),
        .in_last      (in_last),
        .mmu_row0_out (mmu_row0_out),
        .mmu_row1_out (mmu_row1_out),
        .mmu_valid0   (mmu_valid0),
        .mmu_valid1   (mmu_valid1),
        .tile_done    (tile_done),
        .busy         (busy),
        .vec_count    (vec_count),
        .underrun     (underrun)
    );

    always #5 clk = ~clk;

    task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic check_all();
        check_output("row0",      32'(mmu_row0_out), 32'(exp_row0));
        check_output("valid0",    32'(mmu_valid0),   32'(exp_v0));
        check_output("row1",      32'(mmu_row1_out), 32'(exp_row1));
        check_output("valid1",    32'(mmu_valid1),   32'(exp_v1));
        check_output("tile_done", 32'(tile_done),    32'(exp_done));
        check_output("busy",      32'(busy),         32'(m_drain || m_in_tile));
        check_output("vec_count", 32'(vec_count),    32'(m_cnt));
        check_output("underrun",  32'(underrun),     32'(m_und));
    endtask

    task automatic model_clear();
        m_q.delete();
        m_drain   = 0;
        m_in_tile = 0;
        m_cnt     = 0;
        m_und     = 0;
        m_stage_d = '0;
        m_stage_v = 0;
        exp_row0  = '0;
        exp_v0    = 0;
        exp_row1  = '0;
        exp_v1    = 0;
        exp_done  = 0;
    endtask

    // Drives one cycle of input, advances the model across the edge and checks after it
    task automatic apply_stimulus(input bit v, input logic [7:0] a, input logic [7:0] b,
                                  input bit last, output bit accepted);
        vec_t h;
        bit   do_pop;
        in_valid = v;
        in_vec0  = a;
        in_vec1  = b;
        in_last  = last;
        #1;
        check_output("in_ready", 32'(in_ready), 32'(m_q.size() < DEPTH));
        accepted = v && (m_q.size() < DEPTH);
        do_pop   = !m_drain && (m_q.size() > 0);
        exp_row1 = m_stage_d;
        exp_v1   = m_stage_v;
        exp_done = m_drain;
        if (do_pop) begin
            h = m_q.pop_front();
            exp_row0  = h.v0;
            exp_v0    = 1;
            m_stage_d = h.v1;
            m_stage_v = 1;
            if (!m_in_tile) begin
                m_cnt = 1;
                m_und = 0;
            end else if (m_cnt < (1 << CNT_W) - 1) begin
                m_cnt++;
            end
            m_drain   = h.last;
            m_in_tile = !h.last;
        end else begin
            exp_row0  = '0;
            exp_v0    = 0;
            m_stage_d = '0;
            m_stage_v = 0;
            if (m_in_tile) m_und = 1;
            m_drain = 0;
        end
        if (accepted) m_q.push_back('{a, b, last});
        @(posedge clk);
        #1;
        check_all();
    endtask

    task automatic idle(input int n);
        bit acc;
        for (int i = 0; i < n; i++) apply_stimulus(0, 8'h00, 8'h00, 0, acc);
    endtask

    task automatic check_reset_outputs(input string tag);
        check_output({tag, "_row0"},  32'(mmu_row0_out), 32'd0);
        check_output({tag, "_row1"},  32'(mmu_row1_out), 32'd0);
        check_output({tag, "_v0"},    32'(mmu_valid0),   32'd0);
        check_output({tag, "_v1"},    32'(mmu_valid1),   32'd0);
        check_output({tag, "_done"},  32'(tile_done),    32'd0);
        check_output({tag, "_busy"},  32'(busy),         32'd0);
        check_output({tag, "_cnt"},   32'(vec_count),    32'd0);
        check_output({tag, "_und"},   32'(underrun),     32'd0);
        check_output({tag, "_ready"}, 32'(in_ready),     32'd0);
    endtask

    task automatic pulse_reset(input string tag);
        in_valid = 0;
        reset_n  = 0;
        #1;
        check_reset_outputs(tag);
        @(posedge clk);
        #1;
        check_reset_outputs({tag, "_held"});
        reset_n = 1;
        model_clear();
    endtask

    initial begin
        bit         acc;
        bit         saw_low;
        logic [7:0] d0;
        logic [7:0] d1;
        int         sent;

        $display("[TB] start");
        model_clear();
        #1;
        pulse_reset("por");

        $display("[TB] single-vector tile");
        apply_stimulus(1, 8'h03, 8'h05, 1, acc);
        idle(1);
        check_output("single_row0", 32'(mmu_row0_out), 32'h03);
        check_output("single_busy", 32'(busy), 32'd1);
        idle(1);
        check_output("single_row1", 32'(mmu_row1_out), 32'h05);
        check_output("single_done", 32'(tile_done), 32'd1);
        check_output("single_cnt",  32'(vec_count), 32'd1);
        idle(2);

        $display("[TB] back-to-back 4-vector tile");
        for (int i = 1; i <= 4; i++)
            apply_stimulus(1, 8'h10 + 8'(i), 8'h20 + 8'(i), i == 4, acc);
        idle(3);
        check_output("b2b_cnt", 32'(vec_count), 32'd4);
        check_output("b2b_und", 32'(underrun), 32'd0);

        $display("[TB] underrun");
        apply_stimulus(1, 8'($urandom), 8'($urandom), 0, acc);
        apply_stimulus(1, 8'($urandom), 8'($urandom), 0, acc);
        idle(2);
        apply_stimulus(1, 8'($urandom), 8'($urandom), 1, acc);
        idle(3);
        check_output("und_sticky", 32'(underrun), 32'd1);

        $display("[TB] full FIFO");
        saw_low = 0;
        sent    = 0;
        d0 = 8'($urandom);
        d1 = 8'($urandom);
        while (sent < 3 * DEPTH) begin
            if (in_ready === 1'b0) saw_low = 1;
            apply_stimulus(1, d0, d1, 1, acc);
            if (acc) begin
                sent++;
                d0 = 8'($urandom);
                d1 = 8'($urandom);
            end
        end
        idle(2 * DEPTH + 4);
        check_output("full_ready_low", 32'(saw_low), 32'd1);

        $display("[TB] two queued tiles");
        for (int i = 0; i < 4; i++)
            apply_stimulus(1, 8'($urandom), 8'($urandom), (i % 2) == 1, acc);
        idle(5);

        $display("[TB] random traffic");
        for (int i = 0; i < 80; i++)
            apply_stimulus(bit'($urandom_range(0, 1)), 8'($urandom), 8'($urandom),
                           $urandom_range(0, 3) == 0, acc);
        apply_stimulus(1, 8'($urandom), 8'($urandom), 1, acc);
        idle(2 * DEPTH + 4);

        $display("[TB] reset mid-tile");
        apply_stimulus(1, 8'h41, 8'h51, 0, acc);
        apply_stimulus(1, 8'h42, 8'h52, 0, acc);
        apply_stimulus(1, 8'h43, 8'h53, 0, acc);
        pulse_reset("mid");
        idle(3);
        apply_stimulus(1, 8'h77, 8'h88, 1, acc);
        check_output("post_rst_row0", 32'(mmu_row0_out), 32'd0);
        idle(1);
        check_output("post_rst_row0b", 32'(mmu_row0_out), 32'h77);
        idle(3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog timeout");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
